mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter: MAX_LEN, default 16, maximum number of (in, weight) pairs per dot product.
REQ-002 Parameter: LEN_W, default 5, width of the len port; SHALL satisfy 2^LEN_W > MAX_LEN.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 Port: clk, input, 1, rising-edge clock for all state.
REQ-005 Port: reset, input, 1, synchronous active-low reset.
REQ-006 Port: start, input, 1, command request; accepted only when busy=0.
REQ-007 Port: len, input, LEN_W, pair count for the command, sampled on acceptance.
REQ-008 Port: busy, output, 1, high from the cycle after acceptance until the result handshake completes.
REQ-009 Port: s_valid / s_ready, input / output, 1 each, operand stream handshake.
REQ-010 Port: s_in, s_weight, input, 8 each, signed operand pair.
REQ-011 Port: mac_in, mac_weight, output, 8 each, operands driven to the MAC core.
REQ-012 Port: mac_reset, output, 1, active-high accumulator clear to the MAC core.
REQ-013 Port: mac_oe, output, 1, MAC core output enable.
REQ-014 Port: mac_forget, output, 1, tied to 0.
REQ-015 Port: mac_out, input, 8, MAC core result; valid while mac_oe=1.
REQ-016 Port: res_data, output, 8, captured signed result.
REQ-017 Port: res_valid / res_ready, output / input, 1 each, result handshake.
REQ-018 Port: len_err, output, 1, sticky flag set when a command with len > MAX_LEN is accepted.

Function
REQ-019 The FSM SHALL use the states IDLE, CLEAR, FEED, DRAIN and HOLD.
REQ-020 IDLE: when start=1, the command SHALL be accepted, len latched, and the next state SHALL be CLEAR.
REQ-021 In IDLE, busy SHALL be 0; in all other states, busy SHALL be 1.
REQ-022 CLEAR lasts exactly 1 cycle: mac_reset=1, mac_in=mac_weight=0, remaining-count loaded with the latched len.
REQ-023 CLEAR transition: go to FEED if the remaining count > 0, otherwise to DRAIN.
REQ-024 FEED: s_ready SHALL be 1.
REQ-025 FEED: on a cycle with s_valid=1, mac_in=s_in and mac_weight=s_weight combinationally, and the remaining count decrements.
REQ-026 FEED bubble: on a cycle with s_valid=0, mac_in=mac_weight=0 (zero contribution) and the count is held.
REQ-027 FEED transition: after the transfer that brings the count to 0, go to DRAIN on the next edge.
REQ-028 DRAIN lasts exactly 1 cycle: mac_oe=1, operands 0, mac_out registered into res_data at the end of the cycle; then go to HOLD.
REQ-029 HOLD: res_valid=1 and res_data stable; on res_valid && res_ready, go to IDLE.
REQ-030 A start asserted in the same cycle as the HOLD-to-IDLE handshake SHALL be ignored; start is accepted only in IDLE.
REQ-031 Outside FEED, s_ready SHALL be 0; outside DRAIN, mac_oe SHALL be 0; outside CLEAR, mac_reset SHALL be 0.
REQ-032 len > MAX_LEN: the count SHALL saturate to MAX_LEN and len_err SHALL be set; len_err clears only on reset.
REQ-033 len=0: the sequence SHALL be CLEAR, then DRAIN, then HOLD, consuming no stream data.
REQ-034 Latency with zero bubbles: res_valid SHALL rise len+3 cycles after the acceptance edge.
REQ-035 Arithmetic is owned by the MAC core (8-bit wrap); res_data SHALL be an unmodified copy of mac_out.

Reset
REQ-036 While reset=0 at a rising edge, the state SHALL go to IDLE and the counters SHALL clear.
REQ-037 While reset=0, the outputs SHALL be: res_data=0, res_valid=0, busy=0, s_ready=0, mac_oe=0, mac_in=0, mac_weight=0, len_err=0.
REQ-038 While reset=0, mac_reset SHALL be 1 so the core accumulator is cleared.
REQ-039 Reset asserted mid-FEED or mid-HOLD SHALL abandon the command; no res_valid pulse follows.

Verification
REQ-040 len=3 with pairs (2,2) x3, no bubbles -> mac_reset pulse, then 3 FEED cycles, then mac_oe for 1 cycle; res_data=8'd12; res_valid 6 cycles after acceptance.
REQ-041 len=3 with pairs (2,2), (-2,2), (-2,2) -> res_data=8'hFC (-4).
REQ-042 len=2 with s_valid low 2 cycles between the pairs (3,1) and (4,1) -> mac_in=mac_weight=0 in the bubble cycles; res_data=8'd7.
REQ-043 res_ready held 0 for 5 cycles -> res_valid and res_data stable, start ignored; IDLE entered on the cycle after the handshake.
REQ-044 len=0 -> no s_ready assertion; res_data=0 after 3 cycles.
REQ-045 reset=0 for 1 cycle in the second FEED cycle of len=4 -> outputs at reset values, no res_valid; the next len=1 command (5,5) -> res_data=8'd25.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: drives an external MAC core through clear, feed and
// drain phases for one dot product, then holds the result for handoff.
module mac_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_in,
  input  logic [7:0]       s_weight,
  output logic [7:0]       mac_in,
  output logic [7:0]       mac_weight,
  output logic             mac_reset,
  output logic             mac_oe,
  output logic             mac_forget,
  input  logic [7:0]       mac_out,
  output logic [7:0]       res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             len_err
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  state_t           state;
  state_t           nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [7:0]       res_q;
  logic             err_q;
  logic             accept;
  logic             over;
  logic             take;

  assign accept = (state == IDLE) && start;
  assign over   = len > MAXL;
  assign take   = (state == FEED) && s_valid;

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // Command length, remaining count, captured result and sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_q <= '0;
      cnt   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        len_q <= over ? MAXL : len;
        if (over) err_q <= 1'b1;
      end
      if (state == CLEAR) cnt <= len_q;
      else if (take && cnt != '0) cnt <= cnt - ONE;
      if (state == DRAIN) res_q <= mac_out;
    end
  end

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = CLEAR;
      CLEAR: nxt = (len_q != '0) ? FEED : DRAIN;
      FEED:  if (s_valid && cnt == ONE) nxt = DRAIN;
      DRAIN: nxt = HOLD;
      HOLD:  if (res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are forced to their idle values while reset is held low.
  always_comb begin
    busy       = reset && (state != IDLE);
    s_ready    = reset && (state == FEED);
    mac_in     = (reset && take) ? s_in : 8'h00;
    mac_weight = (reset && take) ? s_weight : 8'h00;
    mac_reset  = !reset || (state == CLEAR);
    mac_oe     = reset && (state == DRAIN);
    mac_forget = 1'b0;
    res_valid  = reset && (state == HOLD);
    res_data   = reset ? res_q : 8'h00;
    len_err    = reset && err_q;
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: randomized self-checking bench with a behavioural
// MAC core and a sum-of-products reference for expected results.
module tb_mac_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] len;
  logic       busy;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_in;
  logic [7:0] s_weight;
  logic [7:0] mac_in;
  logic [7:0] mac_weight;
  logic       mac_reset;
  logic       mac_oe;
  logic       mac_forget;
  logic [7:0] mac_out;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       len_err;

  mac_sequencer #(.MAX_LEN(16), .LEN_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_in(s_in),
    .s_weight(s_weight), .mac_in(mac_in), .mac_weight(mac_weight),
    .mac_reset(mac_reset), .mac_oe(mac_oe), .mac_forget(mac_forget),
    .mac_out(mac_out), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Behavioural MAC core: 8-bit wrapping accumulator.
  logic [7:0] acc;
  always @(posedge clk) begin
    if (mac_reset) acc <= 8'h00;
    else acc <= acc + mac_in * mac_weight;
  end
  assign mac_out = mac_oe ? acc : 8'h00;

  int n_chk = 0;
  int n_fail = 0;

  logic signed [7:0] vin [0:31];
  logic signed [7:0] vw  [0:31];

  int r_lat, r_oe, r_mrst, r_bad, r_cons, r_bub, r_rdy;
  int r_hold_bad, r_post_bad, r_to;
  logic [7:0] r_res;

  function automatic logic [7:0] dot(input int n);
    int s;
    int m;
    s = 0;
    m = (n > 16) ? 16 : n;
    for (int i = 0; i < m; i++) s += int'(vin[i]) * int'(vw[i]);
    return 8'(s);
  endfunction

  // Issues one command; records observations for the calling test.
  // r_lat counts rising edges, the acceptance edge being the first.
  task automatic run_cmd(input int n, input int pct, input int gap,
                         input int hold);
    int k;
    int edges;
    int gl;
    bit done;
    k = 0; gl = 0; done = 0;
    r_lat = 0; r_oe = 0; r_mrst = 0; r_bad = 0; r_bub = 0; r_rdy = 0;
    r_hold_bad = 0; r_post_bad = 0; r_to = 0; r_res = 8'h00;
    @(negedge clk);
    start = 1'b1;
    len = 5'(n);
    @(posedge clk);
    edges = 1;
    while (!done && edges < 200) begin
      @(negedge clk);
      start = 1'b0;
      if (k < n && gl == 0 && $urandom_range(99) >= pct) begin
        s_valid = 1'b1; s_in = vin[k]; s_weight = vw[k];
      end else begin
        s_valid = 1'b0; s_in = 8'($urandom); s_weight = 8'($urandom);
        if (gl > 0) gl--;
      end
      #1;
      if (mac_reset) begin
        r_mrst++;
        if (mac_in !== 8'h00 || mac_weight !== 8'h00) r_bad++;
      end
      if (mac_oe) begin
        r_oe++;
        if (mac_in !== 8'h00 || mac_weight !== 8'h00) r_bad++;
      end
      if (s_ready) begin
        r_rdy++;
        if (s_valid) begin
          if (mac_in !== vin[k] || mac_weight !== vw[k]) r_bad++;
          k++;
          gl = gap;
        end else begin
          r_bub++;
          if (mac_in !== 8'h00 || mac_weight !== 8'h00) r_bad++;
        end
      end
      if (res_valid) begin
        done = 1; r_lat = edges; r_res = res_data;
      end else begin
        @(posedge clk);
        edges++;
      end
    end
    s_valid = 1'b0;
    r_cons = k;
    if (!done) begin
      r_to = 1;
    end else begin
      for (int i = 0; i < hold; i++) begin
        start = 1'b1;
        len = 5'($urandom);
        @(negedge clk);
        #1;
        if (!res_valid || res_data !== r_res || !busy) r_hold_bad++;
      end
      start = 1'b1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      res_ready = 1'b0;
      if (busy || res_valid) r_post_bad++;
      @(posedge clk);
      #1;
      if (busy || res_valid || mac_reset) r_post_bad++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({res_data, res_valid, busy, s_ready, mac_oe, len_err}
        !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outs got %h want 0",
               {res_data, res_valid, busy, s_ready, mac_oe, len_err});
    end
    n_chk++;
    if ({mac_in, mac_weight} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_ops got %h want 0", {mac_in, mac_weight});
    end
    n_chk++;
    if (mac_reset !== 1'b1 || mac_forget !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mac got %b%b want 10", mac_reset, mac_forget);
    end
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || mac_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b%b want 00", busy, mac_reset);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 3; i++) begin vin[i] = 2; vw[i] = 2; end
    run_cmd(3, 0, 0, 0);
    n_chk++;
    if (r_to !== 0) begin
      n_fail++; $display("FAIL basic_timeout got %0d want 0", r_to);
    end
    n_chk++;
    if (r_res !== 8'd12) begin
      n_fail++; $display("FAIL basic_res got %0d want 12", r_res);
    end
    n_chk++;
    if (r_lat !== 6) begin
      n_fail++; $display("FAIL basic_lat got %0d want 6", r_lat);
    end
    n_chk++;
    if (r_mrst !== 1 || r_oe !== 1 || r_rdy !== 3) begin
      n_fail++;
      $display("FAIL basic_pulses got rst%0d oe%0d rdy%0d want 1 1 3",
               r_mrst, r_oe, r_rdy);
    end
    n_chk++;
    if (r_bad !== 0 || r_post_bad !== 0) begin
      n_fail++;
      $display("FAIL basic_ops got %0d/%0d want 0/0", r_bad, r_post_bad);
    end
  endtask

  task automatic test_negative;
    vin[0] = 2;  vw[0] = 2;
    vin[1] = -2; vw[1] = 2;
    vin[2] = -2; vw[2] = 2;
    run_cmd(3, 0, 0, 0);
    n_chk++;
    if (r_res !== 8'hFC) begin
      n_fail++; $display("FAIL neg_res got %h want fc", r_res);
    end
  endtask

  task automatic test_bubbles;
    vin[0] = 3; vw[0] = 1;
    vin[1] = 4; vw[1] = 1;
    run_cmd(2, 0, 2, 0);
    n_chk++;
    if (r_res !== 8'd7) begin
      n_fail++; $display("FAIL bub_res got %0d want 7", r_res);
    end
    n_chk++;
    if (r_bub !== 2 || r_bad !== 0) begin
      n_fail++;
      $display("FAIL bub_ops got bub%0d bad%0d want 2 0", r_bub, r_bad);
    end
    n_chk++;
    if (r_lat !== 7) begin
      n_fail++; $display("FAIL bub_lat got %0d want 7", r_lat);
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      vin[i] = 8'($urandom); vw[i] = 8'($urandom);
    end
    run_cmd(5, 0, 0, 5);
    n_chk++;
    if (r_res !== dot(5)) begin
      n_fail++; $display("FAIL hold_res got %h want %h", r_res, dot(5));
    end
    n_chk++;
    if (r_hold_bad !== 0 || r_post_bad !== 0) begin
      n_fail++;
      $display("FAIL hold_stable got %0d/%0d want 0/0",
               r_hold_bad, r_post_bad);
    end
  endtask

  task automatic test_len0;
    run_cmd(0, 0, 0, 0);
    n_chk++;
    if (r_rdy !== 0 || r_res !== 8'h00) begin
      n_fail++;
      $display("FAIL len0 got rdy%0d res%0d want 0 0", r_rdy, r_res);
    end
    n_chk++;
    if (r_lat !== 3 || r_mrst !== 1 || r_oe !== 1) begin
      n_fail++;
      $display("FAIL len0_seq got lat%0d rst%0d oe%0d want 3 1 1",
               r_lat, r_mrst, r_oe);
    end
  endtask

  task automatic test_len_err;
    for (int i = 0; i < 20; i++) begin
      vin[i] = 8'($urandom); vw[i] = 8'($urandom);
    end
    n_chk++;
    if (len_err !== 1'b0) begin
      n_fail++; $display("FAIL err_pre got %b want 0", len_err);
    end
    run_cmd(20, 0, 0, 0);
    n_chk++;
    if (r_cons !== 16 || r_res !== dot(20) || r_lat !== 19) begin
      n_fail++;
      $display("FAIL err_sat got n%0d res%h lat%0d want 16 %h 19",
               r_cons, r_res, r_lat, dot(20));
    end
    run_cmd(2, 0, 0, 0);
    n_chk++;
    if (len_err !== 1'b1 || r_res !== dot(2)) begin
      n_fail++;
      $display("FAIL err_sticky got %b %h want 1 %h", len_err, r_res,
               dot(2));
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    @(negedge clk);
    start = 1'b1; len = 5'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1; s_in = 8'd9; s_weight = 8'd9;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++;
    if ({res_valid, busy, s_ready, mac_oe, len_err, mac_in, mac_weight}
        !== 21'h0 || mac_reset !== 1'b1 || res_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_rst_outs got %b%b%b%b%b %h %h %b %h want zeros",
               res_valid, busy, s_ready, mac_oe, len_err, mac_in,
               mac_weight, mac_reset, res_data);
    end
    @(negedge clk);
    reset = 1'b1;
    s_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid || busy) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL mid_rst_abandon got %0d want 0", bad);
    end
    vin[0] = 5; vw[0] = 5;
    run_cmd(1, 0, 0, 0);
    n_chk++;
    if (r_res !== 8'd25 || len_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_next got %0d err%b want 25 0", r_res, len_err);
    end
  endtask

  task automatic test_random;
    int n;
    int m;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(16);
      m = (n > 16) ? 16 : n;
      for (int i = 0; i < 20; i++) begin
        vin[i] = 8'($urandom); vw[i] = 8'($urandom);
      end
      run_cmd(n, 30, 0, $urandom_range(3));
      n_chk++;
      if (r_to !== 0 || r_res !== dot(n) || r_cons !== m) begin
        n_fail++;
        $display("FAIL rand_res n=%0d got %h/%0d want %h/%0d",
                 n, r_res, r_cons, dot(n), m);
      end
      n_chk++;
      if (r_lat !== m + 3 + r_bub || r_bad !== 0 || r_hold_bad !== 0
          || r_post_bad !== 0) begin
        n_fail++;
        $display("FAIL rand_timing n=%0d got lat%0d bad%0d want %0d 0",
                 n, r_lat, r_bad + r_hold_bad + r_post_bad, m + 3 + r_bub);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; len = '0;
    s_valid = 1'b0; s_in = '0; s_weight = '0; res_ready = 1'b0;
    test_reset;
    test_basic;
    test_negative;
    test_bubbles;
    test_hold;
    test_len0;
    test_len_err;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
